clk_gate_ctrl: RTL and testbench

Enable-side controller for the latch-based clock gating cell. It watches activity requests from the gated domain's clients and closes the gate after a programmable number of consecutive idle cycles. It reopens the gate on any new request and signals clock-ready after a fixed settle latency. It runs on the free-running reference clock; o_Gate_EN drives the gating cell's i_Gate_EN input directly.

---
 rtl/clk_gate_pkg.sv | 8 +
 rtl/clk_gate_idle_timer.sv | 24 ++
 rtl/clk_gate_ctrl.sv | 105 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared FSM encoding and default widths for the clock-gate controller.
package clk_gate_pkg;
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_GATED = 2'd1;
    localparam logic [1:0] ST_WAKE  = 2'd2;
    localparam int IDLE_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/clk_gate_idle_timer.sv
// clk_gate_idle_timer: saturating consecutive-idle counter with live threshold compare.
module clk_gate_idle_timer
    import clk_gate_pkg::*;
#(
    parameter int IDLE_W = IDLE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              count_en_i,
    input  logic [IDLE_W-1:0] thr_i,
    output logic              expire_o
);
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [IDLE_W:0]   cnt_inc;
    // Extra bit keeps a saturated count from wrapping in the compare.
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
    assign expire_o = count_en_i && (thr_i != '0) && (cnt_inc >= {1'b0, thr_i});
    assign cnt_d    = clear_i ? '0 : count_en_i ? (&cnt_q ? cnt_q : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: closes the clock gate after a programmable idle run and reopens it on request.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int IDLE_W   = IDLE_W_DEF,
    parameter int WAKE_LAT = 2,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              i_Ref_clk,
    input  logic              i_Rst,
    input  logic [N_REQ-1:0]  i_Req,
    input  logic              i_Force_on,
    input  logic [IDLE_W-1:0] i_Idle_thr,
    output logic              o_Gate_EN,
    output logic              o_Clk_rdy,
    output logic [1:0]        o_State,
    output logic [CNT_W-1:0]  o_Gate_cnt
);
    localparam int WW = (WAKE_LAT > 1) ? $clog2(WAKE_LAT + 1) : 1;
    localparam logic [WW-1:0] WAKE_INIT = WW'(WAKE_LAT);
    logic [1:0]       state_q, state_d;
    logic             gate_en_q, gate_en_d;
    logic             rdy_q, rdy_d;
    logic [WW-1:0]    wake_q, wake_d;
    logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic             active, run, expire;
    assign active = (|i_Req) | i_Force_on;
    assign run    = (state_q == ST_RUN);
    // Idle count only advances in RUN; any other state, activity or a gate event restarts it.
    clk_gate_idle_timer #(.IDLE_W(IDLE_W)) u_idle (
        .clk_i      (i_Ref_clk),
        .rst_i      (i_Rst),
        .clear_i    (!run || active || expire),
        .count_en_i (run && !active),
        .thr_i      (i_Idle_thr),
        .expire_o   (expire)
    );
    always_comb begin
        state_d    = state_q;
        gate_en_d  = gate_en_q;
        rdy_d      = rdy_q;
        wake_d     = wake_q;
        gate_cnt_d = gate_cnt_q;
        case (state_q)
            ST_RUN: begin
                gate_en_d = 1'b1;
                rdy_d     = 1'b1;
                if (expire) begin
                    state_d    = ST_GATED;
                    gate_en_d  = 1'b0;
                    rdy_d      = 1'b0;
                    gate_cnt_d = &gate_cnt_q ? gate_cnt_q : gate_cnt_q + 1'b1;
                end
            end
            ST_GATED: begin
                gate_en_d = 1'b0;
                rdy_d     = 1'b0;
                if (active) begin
                    gate_en_d = 1'b1;
                    if (WAKE_LAT == 0) begin
                        state_d = ST_RUN;
                        rdy_d   = 1'b1;
                    end else begin
                        state_d = ST_WAKE;
                        wake_d  = WAKE_INIT;
                    end
                end
            end
            ST_WAKE: begin
                gate_en_d = 1'b1;
                rdy_d     = 1'b0;
                wake_d    = wake_q - 1'b1;
                if (wake_q <= WW'(1)) begin
                    state_d = ST_RUN;
                    rdy_d   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_RUN;
                gate_en_d = 1'b1;
                rdy_d     = 1'b1;
            end
        endcase
    end
    always_ff @(posedge i_Ref_clk) begin
        if (i_Rst) begin
            state_q    <= ST_RUN;
            gate_en_q  <= 1'b1;
            rdy_q      <= 1'b1;
            wake_q     <= '0;
            gate_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gate_en_q  <= gate_en_d;
            rdy_q      <= rdy_d;
            wake_q     <= wake_d;
            gate_cnt_q <= gate_cnt_d;
        end
    end
    assign o_Gate_EN  = gate_en_q;
    assign o_Clk_rdy  = rdy_q;
    assign o_State    = state_q;
    assign o_Gate_cnt = gate_cnt_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: scoreboard bench with a cycle-level reference model of the gating rules.
module tb_clk_gate_ctrl;
    localparam int NR = 4;
    localparam int IW = 8;
    localparam int WL = 2;
    localparam int CW = 4;
    localparam int IDLE_MAX = (1 << IW) - 1;
    localparam int CNT_MAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req = '0;
    logic          force_on = 1'b0;
    logic [IW-1:0] thr = '0;
    logic          gate_en, clk_rdy;
    logic [1:0]    st;
    logic [CW-1:0] gate_cnt;

    clk_gate_ctrl #(.N_REQ(NR), .IDLE_W(IW), .WAKE_LAT(WL), .CNT_W(CW)) dut (
        .i_Ref_clk  (clk),
        .i_Rst      (rst),
        .i_Req      (req),
        .i_Force_on (force_on),
        .i_Idle_thr (thr),
        .o_Gate_EN  (gate_en),
        .o_Clk_rdy  (clk_rdy),
        .o_State    (st),
        .o_Gate_cnt (gate_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    st;
        bit    en;
        bit    rdy;
        int    cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=RUN 1=GATED 2=WAKE, idle run length, edge index at which clock is ready.
    int m_mode = 0, m_idle = 0, m_cnt = 0, m_edge = 0, m_ready_at = 0;
    bit m_en = 1'b1, m_rdy = 1'b1;

    task automatic cyc(input string name, input bit r, input logic [NR-1:0] q, input bit f, input int t);
        bit act;
        exp_t e;
        rst = r;
        req = q;
        force_on = f;
        thr = IW'(t);
        act = (q != '0) || f;
        m_edge++;
        if (r) begin
            m_mode = 0; m_en = 1; m_rdy = 1; m_idle = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (!act && t != 0 && m_idle + 1 >= t) begin
                m_mode = 1; m_en = 0; m_rdy = 0; m_idle = 0;
                m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                m_idle = act ? 0 : ((m_idle + 1 > IDLE_MAX) ? IDLE_MAX : m_idle + 1);
            end
        end else if (m_mode == 1) begin
            if (act) begin
                m_mode = 2; m_en = 1; m_ready_at = m_edge + WL;
            end
        end else if (m_edge == m_ready_at) begin
            m_mode = 0; m_rdy = 1; m_idle = 0;
        end
        e.name = name; e.st = m_mode; e.en = m_en; e.rdy = m_rdy; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (int'(st) != e.st || gate_en != e.en || clk_rdy != e.rdy || int'(gate_cnt) != e.cnt) begin
                errors++;
                $display("FAIL %s: got state=%0d en=%0b rdy=%0b cnt=%0d, expected state=%0d en=%0b rdy=%0b cnt=%0d",
                         e.name, st, gate_en, clk_rdy, gate_cnt, e.st, e.en, e.rdy, e.cnt);
            end
        end
    end

    initial begin
        repeat (3) cyc("reset", 1, '0, 0, 4);
        repeat (4) cyc("s1_idle_to_gate", 0, '0, 0, 4);
        cyc("s2_req_pulse", 0, 4'b0100, 0, 4);
        repeat (2) cyc("s2_wake", 0, '0, 0, 4);
        repeat (5) cyc("s2_regate", 0, '0, 0, 4);
        cyc("s3_wake", 0, 4'b0001, 0, 4);
        repeat (3) cyc("s3_wake_done", 0, '0, 0, 4);
        repeat (2) cyc("s3_idle", 0, '0, 0, 4);
        cyc("s3_req", 0, 4'b1000, 0, 4);
        repeat (5) cyc("s3_gate_after_req", 0, '0, 0, 4);
        cyc("s4_wake", 0, 4'b0010, 0, 0);
        repeat (300) cyc("s4_thr0_idle", 0, '0, 0, 0);
        cyc("s4_thr10", 0, '0, 0, 10);
        repeat (20) cyc("s5_force_thr1", 0, '0, 1, 1);
        cyc("s5_force_drop", 0, '0, 0, 1);
        cyc("s5_force_wake", 0, '0, 1, 1);
        repeat (3) cyc("s5_force_hold", 0, '0, 1, 1);
        cyc("s6_gate", 0, '0, 0, 1);
        cyc("s6_req", 0, 4'b0001, 0, 1);
        cyc("s6_wake1", 0, '0, 0, 1);
        cyc("s6_reset_in_wake", 1, '0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc("s6_sat_gate", 0, '0, 0, 1);
            cyc("s6_sat_req", 0, 4'b0001, 0, 1);
            repeat (2) cyc("s6_sat_wake", 0, '0, 0, 1);
        end
        repeat (400) begin
            cyc("random", $urandom_range(0, 99) == 0,
                ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 6));
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
